// File: rtl/ps2_key_sequencer.sv
`timescale 1ns/1ps
// ps2_key_sequencer
//   Sits between the PS/2 receiver FIFO and the display/consumer logic. Each
//   byte is popped with a one-cycle active-low strobe, E0/F0 prefixes are folded
//   into a single key event, the currently held key is tracked so typematic
//   repeats are told apart from new presses, and new presses advance a 2-digit
//   BCD count for the seven-segment display.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   ps2_ready/ps2_data    receiver FIFO non-empty flag and head byte
//   ps2_overflow          receiver FIFO overflow flag
//   ps2_nextdata_n        pop strobe to receiver (active-low, one cycle per byte)
//   cnt_clr               synchronous clear of press count and error flags
//   key_valid             one-cycle event strobe
//   key_code/ext/brk/rpt  event fields, held between strobes
//   key_down/held_code    currently held key
//   cnt_hi/cnt_lo         BCD press count
//   err_overflow/err_code sticky error flags
//
// state  | meaning
// IDLE   | waiting for ps2_ready
// FETCH  | capture head byte
// ACK    | ps2_nextdata_n low for one cycle
// DECODE | classify byte, update held key / count
// WAIT   | ACK_GAP cycles for receiver ready/data to settle
module ps2_key_sequencer #(
    parameter int ACK_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_ready,
    input  logic [7:0] ps2_data,
    input  logic       ps2_overflow,
    output logic       ps2_nextdata_n,
    input  logic       cnt_clr,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       key_rpt,
    output logic       key_down,
    output logic [7:0] held_code,
    output logic [3:0] cnt_lo,
    output logic [3:0] cnt_hi,
    output logic       err_overflow,
    output logic       err_code
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ACK, S_DECODE, S_WAIT} state_t;

    localparam int GW = (ACK_GAP > 1) ? $clog2(ACK_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(ACK_GAP - 1);

    state_t      state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic [GW-1:0] gap_q, gap_d;
    logic        nextdata_n_q, nextdata_n_d;
    logic        ext_pend_q, ext_pend_d;
    logic        brk_pend_q, brk_pend_d;
    logic        key_valid_q, key_valid_d;
    logic [7:0]  key_code_q, key_code_d;
    logic        key_ext_q, key_ext_d;
    logic        key_brk_q, key_brk_d;
    logic        key_rpt_q, key_rpt_d;
    logic        key_down_q, key_down_d;
    logic [7:0]  held_code_q, held_code_d;
    logic        held_ext_q, held_ext_d;
    logic [3:0]  cnt_lo_q, cnt_lo_d;
    logic [3:0]  cnt_hi_q, cnt_hi_d;
    logic        err_ovf_q, err_ovf_d;
    logic        err_code_q, err_code_d;

    logic        inc;
    logic        code_err_set;
    logic        match;

    // Held key identity includes the E0 prefix: plain 75 and E0 75 are different keys.
    assign match = key_down_q && (held_code_q == byte_q) && (held_ext_q == ext_pend_q);

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        gap_d        = gap_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        key_valid_d  = 1'b0;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_brk_d    = key_brk_q;
        key_rpt_d    = key_rpt_q;
        key_down_d   = key_down_q;
        held_code_d  = held_code_q;
        held_ext_d   = held_ext_q;
        cnt_lo_d     = cnt_lo_q;
        cnt_hi_d     = cnt_hi_q;
        err_ovf_d    = err_ovf_q;
        err_code_d   = err_code_q;
        inc          = 1'b0;
        code_err_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ps2_ready) state_d = S_FETCH;
            end
            S_FETCH: begin
                byte_d  = ps2_data;
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_WAIT;
                gap_d   = GAP_LOAD;
                case (byte_q)
                    8'hE0: ext_pend_d = 1'b1;
                    8'hF0: brk_pend_d = 1'b1;
                    8'h00, 8'hFF: begin
                        code_err_set = 1'b1;
                        ext_pend_d   = 1'b0;
                        brk_pend_d   = 1'b0;
                    end
                    default: begin
                        key_valid_d = 1'b1;
                        key_code_d  = byte_q;
                        key_ext_d   = ext_pend_q;
                        key_brk_d   = brk_pend_q;
                        key_rpt_d   = 1'b0;
                        ext_pend_d  = 1'b0;
                        brk_pend_d  = 1'b0;
                        if (brk_pend_q) begin
                            if (match) key_down_d = 1'b0;
                        end else if (match) begin
                            key_rpt_d = 1'b1;
                        end else begin
                            held_code_d = byte_q;
                            held_ext_d  = ext_pend_q;
                            key_down_d  = 1'b1;
                            inc         = 1'b1;
                        end
                    end
                endcase
            end
            S_WAIT: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (inc) begin
            if (cnt_lo_q == 4'd9) begin
                cnt_lo_d = 4'd0;
                cnt_hi_d = (cnt_hi_q == 4'd9) ? 4'd0 : cnt_hi_q + 4'd1;
            end else begin
                cnt_lo_d = cnt_lo_q + 4'd1;
            end
        end

        if (cnt_clr) begin
            cnt_lo_d   = 4'd0;
            cnt_hi_d   = 4'd0;
            err_ovf_d  = 1'b0;
            err_code_d = 1'b0;
        end

        // Error sets land after the clear so a coincident event is never lost.
        if (ps2_overflow) err_ovf_d  = 1'b1;
        if (code_err_set) err_code_d = 1'b1;

        // Registered strobe: low exactly while the FSM sits in ACK.
        nextdata_n_d = (state_d != S_ACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_q       <= 8'h00;
            gap_q        <= '0;
            nextdata_n_q <= 1'b1;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            key_valid_q  <= 1'b0;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            key_brk_q    <= 1'b0;
            key_rpt_q    <= 1'b0;
            key_down_q   <= 1'b0;
            held_code_q  <= 8'h00;
            held_ext_q   <= 1'b0;
            cnt_lo_q     <= 4'd0;
            cnt_hi_q     <= 4'd0;
            err_ovf_q    <= 1'b0;
            err_code_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            gap_q        <= gap_d;
            nextdata_n_q <= nextdata_n_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_brk_q    <= key_brk_d;
            key_rpt_q    <= key_rpt_d;
            key_down_q   <= key_down_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
            cnt_lo_q     <= cnt_lo_d;
            cnt_hi_q     <= cnt_hi_d;
            err_ovf_q    <= err_ovf_d;
            err_code_q   <= err_code_d;
        end
    end

    assign ps2_nextdata_n = nextdata_n_q;
    assign key_valid      = key_valid_q;
    assign key_code       = key_code_q;
    assign key_ext        = key_ext_q;
    assign key_brk        = key_brk_q;
    assign key_rpt        = key_rpt_q;
    assign key_down       = key_down_q;
    assign held_code      = held_code_q;
    assign cnt_lo         = cnt_lo_q;
    assign cnt_hi         = cnt_hi_q;
    assign err_overflow   = err_ovf_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
`timescale 1ns/1ps
// Testbench for ps2_key_sequencer: a queue models the receiver FIFO, expected
// key events are pushed to a scoreboard and a monitor compares them whenever
// key_valid strobes.
module tb_ps2_key_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_ready = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_overflow = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       ps2_nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext, key_brk, key_rpt, key_down;
    logic [7:0] held_code;
    logic [3:0] cnt_lo, cnt_hi;
    logic       err_overflow, err_code;

    ps2_key_sequencer #(.ACK_GAP(2)) dut (
        .clk(clk), .rst(rst),
        .ps2_ready(ps2_ready), .ps2_data(ps2_data), .ps2_overflow(ps2_overflow),
        .ps2_nextdata_n(ps2_nextdata_n), .cnt_clr(cnt_clr),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_brk(key_brk), .key_rpt(key_rpt), .key_down(key_down),
        .held_code(held_code), .cnt_lo(cnt_lo), .cnt_hi(cnt_hi),
        .err_overflow(err_overflow), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       ext, brk, rpt, down;
        logic [7:0] held;
        logic [3:0] hi, lo;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         low_cycles = 0;
    exp_t       mon_exp, mon_act;

    task automatic refresh();
        ps2_ready = (fifo.size() != 0);
        ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        refresh();
    endtask

    task automatic push_exp(input logic [7:0] code, input logic ext, input logic brk,
                            input logic rpt, input logic down, input logic [7:0] held,
                            input logic [3:0] hi, input logic [3:0] lo);
        exp_t e;
        e = '{code: code, ext: ext, brk: brk, rpt: rpt, down: down, held: held, hi: hi, lo: lo};
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (fifo.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] all_outs();
        return {ps2_nextdata_n, key_valid, key_code, key_ext, key_brk, key_rpt, key_down,
                held_code, cnt_hi, cnt_lo, err_overflow, err_code};
    endfunction

    // Receiver model: one pop per cycle the strobe is seen low.
    always @(negedge clk) begin
        if (!rst && !ps2_nextdata_n) begin
            low_cycles++;
            if (fifo.size() != 0) begin
                void'(fifo.pop_front());
                refresh();
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (key_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got code %h ext %b brk %b, none expected",
                         key_code, key_ext, key_brk);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_act = '{code: key_code, ext: key_ext, brk: key_brk, rpt: key_rpt,
                            down: key_down, held: held_code, hi: cnt_hi, lo: cnt_lo};
                if (mon_act !== mon_exp) begin
                    miscompares++;
                    $display("FAIL event: got code %h ext %b brk %b rpt %b down %b held %h cnt %h%h; expected code %h ext %b brk %b rpt %b down %b held %h cnt %h%h",
                             mon_act.code, mon_act.ext, mon_act.brk, mon_act.rpt, mon_act.down,
                             mon_act.held, mon_act.hi, mon_act.lo,
                             mon_exp.code, mon_exp.ext, mon_exp.brk, mon_exp.rpt, mon_exp.down,
                             mon_exp.held, mon_exp.hi, mon_exp.lo);
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 32'h8000_0000);
        rst = 1'b0;
        @(negedge clk);

        // 1: single make
        low_cycles = 0;
        push_byte(8'h1C);
        push_exp(8'h1C, 0, 0, 0, 1, 8'h1C, 4'd0, 4'd1);
        wait_idle();
        check("ack_low_cycles_1", low_cycles, 32'd1);

        // release, clear count, then 2: repeats and break
        push_byte(8'hF0); push_byte(8'h1C);
        push_exp(8'h1C, 0, 1, 0, 0, 8'h1C, 4'd0, 4'd1);
        wait_idle();
        pulse_clr();
        check("clr_keeps_held", {key_down, held_code}, {1'b0, 8'h1C});
        low_cycles = 0;
        push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
        push_exp(8'h1C, 0, 0, 0, 1, 8'h1C, 4'd0, 4'd1);
        push_exp(8'h1C, 0, 0, 1, 1, 8'h1C, 4'd0, 4'd1);
        push_exp(8'h1C, 0, 0, 1, 1, 8'h1C, 4'd0, 4'd1);
        push_exp(8'h1C, 0, 1, 0, 0, 8'h1C, 4'd0, 4'd1);
        wait_idle();
        check("ack_low_cycles_5", low_cycles, 32'd5);

        // 3: extended keys
        pulse_clr();
        push_byte(8'hE0); push_byte(8'h75); push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
        push_exp(8'h75, 1, 0, 0, 1, 8'h75, 4'd0, 4'd1);
        push_exp(8'h75, 1, 1, 0, 0, 8'h75, 4'd0, 4'd1);
        push_byte(8'hE0); push_byte(8'h75); push_byte(8'h75);
        push_exp(8'h75, 1, 0, 0, 1, 8'h75, 4'd0, 4'd2);
        push_exp(8'h75, 0, 0, 0, 1, 8'h75, 4'd0, 4'd3);
        push_byte(8'hF0); push_byte(8'h1C);
        push_exp(8'h1C, 0, 1, 0, 1, 8'h75, 4'd0, 4'd3);
        wait_idle();

        // 4: count wrap and clear-vs-increment
        pulse_clr();
        push_byte(8'hFF);
        wait_idle();
        check("err_code_set_4", err_code, 1'b1);
        for (int i = 1; i <= 100; i++) begin
            push_byte((i % 2) ? 8'h15 : 8'h16);
            push_exp((i % 2) ? 8'h15 : 8'h16, 0, 0, 0, 1, (i % 2) ? 8'h15 : 8'h16,
                     4'((i % 100) / 10), 4'(i % 10));
        end
        wait_idle();
        check("cnt_wrap", {cnt_hi, cnt_lo}, 8'h00);
        cnt_clr = 1'b1;
        push_byte(8'h15);
        push_exp(8'h15, 0, 0, 0, 1, 8'h15, 4'd0, 4'd0);
        wait_idle();
        check("clr_wins_cnt", {cnt_hi, cnt_lo}, 8'h00);
        check("clr_err_code", err_code, 1'b0);
        cnt_clr = 1'b0;
        @(negedge clk);

        // 5: error flags
        push_byte(8'hFF);
        wait_idle();
        check("err_code_set_5", err_code, 1'b1);
        ps2_overflow = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        check("err_ovf_set", err_overflow, 1'b1);
        repeat (5) @(negedge clk);
        check("err_ovf_sticky", err_overflow, 1'b1);
        pulse_clr();
        check("err_cleared", {err_overflow, err_code}, 2'b00);
        ps2_overflow = 1'b1;
        cnt_clr = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        cnt_clr = 1'b0;
        check("ovf_beats_clr", err_overflow, 1'b1);

        // 6: reset during ACK, stale prefix discarded
        push_byte(8'hE0);
        wait_idle();
        push_byte(8'h22);
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            #1;
            if (!ps2_nextdata_n) break;
            n++;
        end
        check("ack_reached", ps2_nextdata_n, 1'b0);
        rst = 1'b1;
        #1;
        check("reset_mid_ack", all_outs(), 32'h8000_0000);
        @(negedge clk);
        fifo.delete();
        refresh();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_byte(8'h33);
        push_exp(8'h33, 0, 0, 0, 1, 8'h33, 4'd0, 4'd1);
        wait_idle();

        check("events_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
